// File: rtl/key_event_encoder.sv
// Piano key event source: synchronises and debounces three active-low keys,
// then queues press/release events in a first-word-fall-through FIFO.
module key_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] key_n,
    output logic [2:0] key_state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_key,
    output logic       evt_press,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       r_sync1, r_sync2;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       r_state;
    logic [2:0]       r_pend;
    logic [2:0]       r_pend_press;
    logic             r_overflow;

    logic [1:0]       r_mem_key   [FIFO_DEPTH];
    logic             r_mem_press [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic [2:0] w_sync;
    logic [2:0] w_accept;
    logic [2:0] w_grant;
    logic [1:0] w_sel;
    logic       w_sel_press;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_valid;

    assign w_sync  = ~r_sync2;
    assign w_full  = (r_occ == OCC_W'(FIFO_DEPTH));
    assign w_valid = (r_occ != '0);
    assign w_push  = |w_grant;
    assign w_pop   = w_valid && evt_ready;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_accept[i] = (w_sync[i] != r_state[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    // Fixed-priority arbiter: lowest pending key index wins, blocked when full.
    always_comb begin
        w_sel       = 2'd0;
        w_sel_press = 1'b0;
        w_grant     = 3'b000;
        if (r_pend[0]) begin
            w_sel       = 2'd0;
            w_sel_press = r_pend_press[0];
            w_grant     = 3'b001;
        end else if (r_pend[1]) begin
            w_sel       = 2'd1;
            w_sel_press = r_pend_press[1];
            w_grant     = 3'b010;
        end else if (r_pend[2]) begin
            w_sel       = 2'd2;
            w_sel_press = r_pend_press[2];
            w_grant     = 3'b100;
        end
        if (w_full) begin
            w_grant = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1      <= 3'b111;
            r_sync2      <= 3'b111;
            r_state      <= 3'b000;
            r_pend       <= 3'b000;
            r_pend_press <= 3'b000;
            r_overflow   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
                if (w_sync[i] == r_state[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_state[i]      <= w_sync[i];
                    r_cnt[i]        <= '0;
                    r_pend[i]       <= 1'b1;
                    r_pend_press[i] <= w_sync[i];
                    // An unpushed event for this key is being replaced.
                    if (r_pend[i] && !w_grant[i]) begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_key[r_wr_ptr]   <= w_sel;
            r_mem_press[r_wr_ptr] <= w_sel_press;
        end
    end

    assign key_state = r_state;
    assign overflow  = r_overflow;
    assign evt_valid = w_valid;
    assign evt_key   = w_valid ? r_mem_key[r_rd_ptr] : 2'd0;
    assign evt_press = w_valid ? r_mem_press[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with a short debounce window.
module tb_key_event_encoder;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] key_n;
    logic [2:0] key_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_key;
    logic       evt_press;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    key_event_encoder #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .key_n(key_n),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key(evt_key),
        .evt_press(evt_press),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_head(input string tag, input int k, input int p);
        chk({tag, "_valid"}, 32'(evt_valid), 1);
        chk({tag, "_key"},   32'(evt_key),   32'(k));
        chk({tag, "_press"}, 32'(evt_press), 32'(p));
    endtask

    int exp_k [5] = '{0, 1, 2, 0, 0};
    int exp_p [5] = '{0, 0, 0, 1, 1};

    initial begin
        resetn    = 1'b0;
        key_n     = 3'b111;
        evt_ready = 1'b0;
        step(3);
        chk("rst_state", 32'(key_state), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_key",   32'(evt_key),   0);
        chk("rst_press", 32'(evt_press), 0);
        chk("rst_ovf",   32'(overflow),  0);
        resetn = 1'b1;

        for (int c = 0; c < 50; c++) begin
            step(1);
            chk("idle_state", 32'(key_state), 0);
            chk("idle_valid", 32'(evt_valid), 0);
            chk("idle_ovf",   32'(overflow),  0);
        end

        // Single press then release of do, with consumer always ready
        evt_ready = 1'b1;
        key_n     = 3'b110;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            chk("press_early", 32'(evt_valid), 0);
        end
        step(1);
        chk_head("press_e7", 0, 1);
        chk("press_state", 32'(key_state), 1);
        step(1);
        chk("press_pulse_end", 32'(evt_valid), 0);

        key_n = 3'b111;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            chk("rel_early", 32'(evt_valid), 0);
        end
        step(1);
        chk_head("rel_e7", 0, 0);
        chk("rel_state", 32'(key_state), 0);
        step(1);
        chk("rel_pulse_end", 32'(evt_valid), 0);

        // Short glitch on re must be filtered
        key_n = 3'b101;
        step(3);
        key_n = 3'b111;
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("glitch_valid", 32'(evt_valid), 0);
            chk("glitch_state", 32'(key_state), 0);
        end

        // All three keys at once, queued in index order
        evt_ready = 1'b0;
        key_n     = 3'b000;
        step(6);
        chk("multi_e6", 32'(evt_valid), 0);
        step(1);
        chk_head("multi_e7", 0, 1);
        step(2);
        chk("multi_state", 32'(key_state), 7);
        step(3);
        evt_ready = 1'b1;
        chk_head("drain0", 0, 1);
        step(1);
        chk_head("drain1", 1, 1);
        step(1);
        chk_head("drain2", 2, 1);
        step(1);
        chk("drain_empty", 32'(evt_valid), 0);

        // Fill the FIFO, hold a fifth event pending, then overwrite it
        evt_ready = 1'b0;
        key_n     = 3'b111;
        step(10);
        chk_head("fill_head", 0, 0);
        chk("fill_state0", 32'(key_state), 0);
        key_n = 3'b110;
        step(10);
        chk("fill_state1", 32'(key_state), 1);
        key_n = 3'b111;
        step(10);
        chk("fill_state2", 32'(key_state), 0);
        chk("fill_ovf_clear", 32'(overflow), 0);
        chk_head("fill_head_hold", 0, 0);
        key_n = 3'b110;
        step(10);
        chk("ovf_set", 32'(overflow), 1);
        evt_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk_head("ovf_drain", exp_k[n], exp_p[n]);
            step(1);
        end
        chk("ovf_drain_empty", 32'(evt_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Asynchronous reset with queued events and a debounce in flight
        evt_ready = 1'b0;
        key_n     = 3'b001;
        step(12);
        chk_head("prerst_head", 0, 0);
        key_n = 3'b011;
        step(4);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid), 0);
        chk("arst_state", 32'(key_state), 0);
        chk("arst_key",   32'(evt_key),   0);
        chk("arst_press", 32'(evt_press), 0);
        chk("arst_ovf",   32'(overflow),  0);
        key_n = 3'b111;
        step(3);
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("post_rst_valid", 32'(evt_valid), 0);
            chk("post_rst_state", 32'(key_state), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_event_encoder.md
Name: key_event_encoder

Overview:
- Front end of the piano keyboard drawing path: the event source that feeds the key-drawing datapath.
- Takes three raw active-low key inputs (do, re, mi), then synchronises and debounces them.
- Detects press and release transitions and queues each as an event (key index plus press/release flag) in a small FIFO.
- The FIFO is drained by the drawing logic through a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised key level must differ from the stable level before it is accepted (≥2).
- CNT_W, 16, width of each per-key debounce counter; must hold DEBOUNCE_CYCLES-1.
- FIFO_DEPTH, 4, event queue depth; power of two, ≥2.

Ports:
- clk  input  1  system clock (50 MHz on board).
- resetn  input  1  asynchronous active-low reset.
- key_n  input  3  raw key inputs, asynchronous, 0 = pressed; bit0 = do, bit1 = re, bit2 = mi.
- key_state  output  3  debounced key levels, 1 = pressed.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts the head event this cycle.
- evt_key  output  2  key index of the head event (0 = do, 1 = re, 2 = mi); 0 when empty.
- evt_press  output  1  head event type: 1 = press, 0 = release; 0 when empty.
- overflow  output  1  sticky flag: an event was lost; cleared only by reset.

Behaviour:
- Reset (asynchronous, resetn = 0):
  - Sync flops reset to 1 (released).
  - key_state = 000, all counters 0, pending flags cleared.
  - FIFO empty, so evt_valid = 0, evt_key = 0, evt_press = 0.
  - overflow = 0.
  - Reset asserted mid-operation discards all queued and pending events immediately.
- Synchronisation: each key_n bit passes through two flops; the inverted output is sync[i].
- Debounce, per key i, each edge:
  - If sync[i] == key_state[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: key_state[i] <= sync[i], cnt[i] <= 0, pending[i] <= 1, pend_press[i] <= sync[i].
  - Else: cnt[i] <= cnt[i]+1.
  - Any return of sync to the stable level before acceptance clears the counter, so bounces shorter than DEBOUNCE_CYCLES produce no event.
- Latency: evt_valid is high following the (DEBOUNCE_CYCLES+3)th rising edge after a clean key_n change, with the FIFO previously empty:
  - 2 edges for synchronisation,
  - DEBOUNCE_CYCLES edges for debounce,
  - 1 edge for the FIFO write.
- Arbiter:
  - Each cycle the lowest-index set pending[i] is pushed as {i, pend_press[i]}, and that flag is cleared on the same edge.
  - A push occurs only when the FIFO is not full at the start of the cycle; a simultaneous pop does not create room that cycle.
  - At most one push per cycle; remaining pending keys wait.
- Pending overwrite: if key_state[i] changes again while pending[i] is still set, pend_press[i] takes the new value and overflow <= 1 (the older event is lost).
- FIFO:
  - First-word-fall-through: evt_key and evt_press always show the head.
  - Pop on evt_valid && evt_ready.
  - evt_ready while empty has no effect.
  - Push and pop in the same cycle leave the occupancy unchanged; order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter ranges 0..FIFO_DEPTH.
- Simultaneous events: keys accepted on the same edge are queued in index order (do, re, mi) on consecutive cycles.
- Outputs are registered or driven from the FIFO head only; there are no combinational paths from key_n to the outputs.

Test Plan:
- Reset then idle, DEBOUNCE_CYCLES = 4, key_n = 111 -> key_state = 000, evt_valid = 0, overflow = 0 for 50 cycles.
- key_n[0] falls and is held, evt_ready = 1 -> evt_valid pulses for 1 cycle at the 7th edge with evt_key = 0, evt_press = 1, and key_state = 001. Releasing later gives evt_key = 0, evt_press = 0.
- key_n[1] glitches low for 3 cycles, then returns high -> no event, key_state unchanged.
- key_n = 000 all at once, evt_ready = 0 -> three events queued in order (0,1), (1,1), (2,1) on consecutive cycles. Raising evt_ready then drains them in that order.
- evt_ready = 0, 5 distinct debounced transitions with FIFO_DEPTH = 4 -> 4 events queued, the 5th held pending. A further change on that same key sets overflow = 1, which stays set until resetn.
- resetn pulsed low with 3 events queued and a debounce in progress -> evt_valid = 0 immediately (asynchronous), key_state = 000, and no stale events after release.
